run_sample_transmitter: RTL and testbench



---
 rtl/run_link_pkg.sv | 33 +++
 rtl/sample_fifo.sv | 63 ++++++
 rtl/run_sample_transmitter.sv | 146 ++++++++++++++
 tb/tb_run_sample_transmitter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_link_pkg.sv
// Shared widths, sample payload and FSM encoding for the run-sample link.
package run_link_pkg;

    localparam int unsigned HR_W       = 8;
    localparam int unsigned STEP_W     = 2;
    localparam int unsigned STRIDE_W   = 8;
    localparam int unsigned HR_MIN_DEF = 30;
    localparam int unsigned HR_MAX_DEF = 220;

    typedef struct packed {
        logic [HR_W-1:0]     hr;
        logic [STEP_W-1:0]   steps;
        logic [STRIDE_W-1:0] stride;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Saturate a raw heart rate into [lo, hi].
    function automatic logic [HR_W-1:0] clamp_hr(
        input logic [HR_W-1:0] hr,
        input logic [HR_W-1:0] lo,
        input logic [HR_W-1:0] hi
    );
        if (hr > hi) return hi;
        if (hr < lo) return lo;
        return hr;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; head is read combinationally.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             full_next_c,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_c = (count_q == '0);
    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && !empty_c;
    assign head_c  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy update; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_next_c = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/run_sample_transmitter.sv
// Buffers sensor run samples and replays them as paced one-cycle strobes to a step calculator.
module run_sample_transmitter
    import run_link_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned INTERVAL_CYCLES = 2,
    parameter int unsigned HR_MAX          = HR_MAX_DEF,
    parameter int unsigned HR_MIN          = HR_MIN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [HR_W-1:0]               in_hr,
    input  logic [STEP_W-1:0]             in_steps,
    input  logic [STRIDE_W-1:0]           in_stride,
    output logic [HR_W-1:0]               hr_input,
    output logic [STEP_W-1:0]             steps_per_second,
    output logic [STRIDE_W-1:0]           stride_length,
    output logic                          valid_input,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    underrun_count,
    output logic [7:0]                    drop_count,
    output logic                          hr_clamped
);

    localparam int unsigned IV_W   = $clog2(INTERVAL_CYCLES);
    localparam int unsigned SMP_W  = $bits(sample_t);

    state_t             state_q, state_d;
    logic [IV_W-1:0]    ivl_q, ivl_d;
    sample_t            out_q, out_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [7:0]         underrun_q, underrun_d;
    logic [7:0]         drop_q, drop_d;
    logic               clamped_q, clamped_d;

    logic               tick;
    logic               push;
    logic               pop;
    logic               underrun_inc;
    sample_t            wr_sample;
    logic [SMP_W-1:0]   head_bits;
    logic               fifo_empty;
    logic               fifo_full_next;

    assign push = in_valid && ready_q;
    assign tick = enable && (ivl_q == IV_W'(INTERVAL_CYCLES - 1));

    // Heart rate is clamped on the way in; steps and stride pass untouched.
    always_comb begin
        wr_sample.hr     = clamp_hr(in_hr, HR_W'(HR_MIN), HR_W'(HR_MAX));
        wr_sample.steps  = in_steps;
        wr_sample.stride = in_stride;
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SMP_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     (wr_sample),
        .head_c      (head_bits),
        .empty_c     (fifo_empty),
        .full_next_c (fifo_full_next),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        underrun_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        underrun_inc = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                state_d = enable ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Interval pacing, output staging and saturating status counters.
    always_comb begin
        ivl_d = '0;
        if (enable && !tick) ivl_d = ivl_q + IV_W'(1);
        out_d      = pop ? sample_t'(head_bits) : out_q;
        valid_d    = pop;
        ready_d    = !fifo_full_next;
        underrun_d = underrun_q;
        if (underrun_inc && (underrun_q != 8'hFF)) underrun_d = underrun_q + 8'd1;
        drop_d = drop_q;
        if (in_valid && !ready_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        clamped_d = clamped_q | (push && (wr_sample.hr != in_hr));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ivl_q      <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= '0;
            drop_q     <= '0;
            clamped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ivl_q      <= ivl_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            drop_q     <= drop_d;
            clamped_q  <= clamped_d;
        end
    end

    assign in_ready         = ready_q;
    assign hr_input         = out_q.hr;
    assign steps_per_second = out_q.steps;
    assign stride_length    = out_q.stride;
    assign valid_input      = valid_q;
    assign underrun_count   = underrun_q;
    assign drop_count       = drop_q;
    assign hr_clamped       = clamped_q;

endmodule

// File: tb/tb_run_sample_transmitter.sv
// Directed bench for run_sample_transmitter with hand-computed expectations.
module tb_run_sample_transmitter;

    localparam int INTERVAL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_hr;
    logic [1:0] in_steps;
    logic [7:0] in_stride;
    logic [7:0] hr_input;
    logic [1:0] steps_per_second;
    logic [7:0] stride_length;
    logic       valid_input;
    logic [2:0] fifo_count;
    logic [7:0] underrun_count;
    logic [7:0] drop_count;
    logic       hr_clamped;

    int tests = 0;
    int fails = 0;

    logic [7:0] push_hr [8];
    logic [7:0] exp_hr  [8];

    run_sample_transmitter #(
        .FIFO_DEPTH      (4),
        .INTERVAL_CYCLES (INTERVAL),
        .HR_MAX          (220),
        .HR_MIN          (30)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_hr            (in_hr),
        .in_steps         (in_steps),
        .in_stride        (in_stride),
        .hr_input         (hr_input),
        .steps_per_second (steps_per_second),
        .stride_length    (stride_length),
        .valid_input      (valid_input),
        .fifo_count       (fifo_count),
        .underrun_count   (underrun_count),
        .drop_count       (drop_count),
        .hr_clamped       (hr_clamped)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic push(input logic [7:0] hr, input logic [1:0] st, input logic [7:0] sd);
        in_valid  = 1'b1;
        in_hr     = hr;
        in_steps  = st;
        in_stride = sd;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, valid_input, 0);
        check({tag, "_hr"}, hr_input, 0);
        check({tag, "_steps"}, steps_per_second, 0);
        check({tag, "_stride"}, stride_length, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_underrun"}, underrun_count, 0);
        check({tag, "_drop"}, drop_count, 0);
        check({tag, "_clamped"}, hr_clamped, 0);
        check({tag, "_ready"}, in_ready, 0);
    endtask

    // Watch a bounded window: pulse order, spacing, and data hold between pulses.
    task automatic collect(input int npush, input int nexp, input int max_cyc, input logic [7:0] hold_hr);
        int         seen = 0;
        int         last = -100;
        logic [7:0] cur  = hold_hr;
        for (int c = 0; c < max_cyc; c++) begin
            if (valid_input) begin
                if (seen < nexp) begin
                    check("pulse_hr", hr_input, exp_hr[seen]);
                    cur = exp_hr[seen];
                end
                if (seen > 0) check("pulse_gap", c - last, INTERVAL);
                last = c;
                seen++;
            end else begin
                check("hold_hr", hr_input, cur);
            end
            if (c < npush) begin
                in_valid  = 1'b1;
                in_hr     = push_hr[c];
                in_steps  = 2'd1;
                in_stride = 8'd80;
            end else begin
                in_valid = 1'b0;
            end
            step(1);
        end
        in_valid = 1'b0;
        check("pulse_count", seen, nexp);
    endtask

    initial begin
        in_hr     = '0;
        in_steps  = '0;
        in_stride = '0;

        // Reset state and first emission latency.
        do_reset();
        rst = 1'b0;
        step(2);
        check_zero("reset");
        rst = 1'b1;
        step(1);
        check("ready_after_reset", in_ready, 1);
        enable = 1'b1;
        push(8'd121, 2'd2, 8'd75);
        check("basic_wait_valid", valid_input, 0);
        check("basic_wait_count", fifo_count, 1);
        step(1);
        check("basic_valid", valid_input, 1);
        check("basic_hr", hr_input, 121);
        check("basic_steps", steps_per_second, 2);
        check("basic_stride", stride_length, 75);
        check("basic_count", fifo_count, 0);
        step(1);
        check("basic_pulse_end", valid_input, 0);
        check("basic_hold_hr", hr_input, 121);
        check("basic_hold_stride", stride_length, 75);

        // Back-to-back pushes drain in order at the interval spacing.
        push_hr[0] = 8'd121; push_hr[1] = 8'd132; push_hr[2] = 8'd143; push_hr[3] = 8'd154;
        exp_hr[0]  = 8'd121; exp_hr[1]  = 8'd132; exp_hr[2]  = 8'd143; exp_hr[3]  = 8'd154;
        collect(4, 4, 20, 8'd121);
        check("pace_count", fifo_count, 0);

        // Overflow with emission disabled, then drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_hr     = 8'(100 + i);
            in_steps  = 2'd3;
            in_stride = 8'd90;
            step(1);
            if (i == 3) begin
                check("ovf_full_ready", in_ready, 0);
                check("ovf_full_count", fifo_count, 4);
            end
        end
        check("ovf_drop", drop_count, 2);
        step(252);
        check("ovf_drop_254", drop_count, 254);
        step(3);
        check("ovf_drop_sat", drop_count, 255);
        in_valid = 1'b0;
        check("ovf_count_kept", fifo_count, 4);
        enable = 1'b1;
        step(1);
        check("ovf_ready_tick", in_ready, 0);
        step(1);
        check("ovf_first_valid", valid_input, 1);
        check("ovf_first_hr", hr_input, 100);
        check("ovf_first_steps", steps_per_second, 3);
        check("ovf_ready_after_pop", in_ready, 1);
        check("ovf_count_after_pop", fifo_count, 3);
        step(1);
        exp_hr[0] = 8'd101; exp_hr[1] = 8'd102; exp_hr[2] = 8'd103;
        collect(0, 3, 10, 8'd100);
        check("ovf_drained", fifo_count, 0);

        // Underrun counting and saturation.
        do_reset();
        enable = 1'b1;
        begin
            int pulses = 0;
            for (int i = 0; i < 20; i++) begin
                step(1);
                if (valid_input) pulses++;
            end
            check("under_no_pulse", pulses, 0);
        end
        check("under_10", underrun_count, 10);
        step(488);
        check("under_254", underrun_count, 254);
        step(4);
        check("under_sat", underrun_count, 255);

        // Heart-rate clamping at and beyond both bounds.
        do_reset();
        push(8'd220, 2'd1, 8'd70);
        check("clamp_at_max", hr_clamped, 0);
        push(8'd30, 2'd1, 8'd70);
        check("clamp_at_min", hr_clamped, 0);
        push(8'd250, 2'd1, 8'd70);
        check("clamp_high", hr_clamped, 1);
        push(8'd10, 2'd1, 8'd70);
        check("clamp_low", hr_clamped, 1);
        enable = 1'b1;
        exp_hr[0] = 8'd220; exp_hr[1] = 8'd30; exp_hr[2] = 8'd220; exp_hr[3] = 8'd30;
        collect(0, 4, 14, 8'd0);
        check("clamp_sticky", hr_clamped, 1);

        // Enable dropped during a pulse, then reset with samples queued mid-pulse.
        enable = 1'b0;
        push(8'd60, 2'd1, 8'd80);
        push(8'd61, 2'd1, 8'd80);
        push(8'd62, 2'd1, 8'd80);
        enable = 1'b1;
        step(2);
        check("mid_valid", valid_input, 1);
        check("mid_hr", hr_input, 60);
        enable = 1'b0;
        step(1);
        check("mid_pulse_end", valid_input, 0);
        check("mid_count_kept", fifo_count, 2);
        step(4);
        check("mid_idle_valid", valid_input, 0);
        check("mid_idle_count", fifo_count, 2);
        check("mid_idle_hold", hr_input, 60);
        enable = 1'b1;
        step(1);
        check("mid_reenable_wait", valid_input, 0);
        step(1);
        check("mid_reenable_valid", valid_input, 1);
        check("mid_reenable_hr", hr_input, 61);
        enable = 1'b0;
        push(8'd63, 2'd1, 8'd80);
        push(8'd64, 2'd1, 8'd80);
        push(8'd65, 2'd1, 8'd80);
        check("mid_refill", fifo_count, 4);
        enable = 1'b1;
        step(2);
        check("mid_emit_62", hr_input, 62);
        check("mid_emit_valid", valid_input, 1);
        check("mid_queued", fifo_count, 3);
        rst = 1'b0;
        step(1);
        check_zero("rst_mid_emit");
        rst    = 1'b1;
        enable = 1'b0;
        step(1);
        check("rst_release_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
